// File: rtl/can_bit_destuff.sv
// Purpose: removes CAN stuff bits from the sampled Rx stream and flags stuff-rule violations.
// Latency: dout/dvalid/stuff_drop/stuff_err are registered, 1 clk after the triggering dvalid_in.
// Backpressure: none; one bit accepted per dvalid_in pulse, downstream must take every dvalid.
module can_bit_destuff #(
  parameter int STUFF_LEN = 5,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din_in,
  input  logic       dvalid_in,
  input  logic       sof,
  input  logic       stuff_region,
  input  logic       sample_en,
  output logic       dout,
  output logic       dvalid,
  output logic       stuff_drop,
  output logic       stuff_err,
  output logic [7:0] stuff_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] run_cnt;
  logic             last_bit;

  // Frame FSM, run-length tracking and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      run_cnt    <= '0;
      last_bit   <= 1'b1;
      dout       <= 1'b1;
      dvalid     <= 1'b0;
      stuff_drop <= 1'b0;
      stuff_err  <= 1'b0;
      stuff_cnt  <= 8'd0;
    end else begin
      // Pulses default low; only a qualifying bit raises one for a single clk.
      dvalid     <= 1'b0;
      stuff_drop <= 1'b0;
      stuff_err  <= 1'b0;
      case (state)
        IDLE: begin
          // Only a dominant SOF bit opens a frame; the SOF bit is the first of the run.
          if (dvalid_in && sof && !din_in) begin
            dvalid    <= 1'b1;
            dout      <= 1'b0;
            run_cnt   <= RUN_ONE;
            last_bit  <= 1'b0;
            stuff_cnt <= 8'd0;
            state     <= RUN;
          end
        end
        RUN: begin
          // Losing sample_en ends the frame even in cycles without a bit.
          if (!sample_en) begin
            state <= IDLE;
          end else if (dvalid_in) begin
            if (!stuff_region) begin
              // Outside the stuffed fields: pass through and restart counting on re-entry.
              dvalid  <= 1'b1;
              dout    <= din_in;
              run_cnt <= '0;
            end else if (run_cnt == RUN_MAX && din_in != last_bit) begin
              // Stuff bit: dropped, but it begins the next run of equal bits.
              stuff_drop <= 1'b1;
              if (stuff_cnt != 8'hFF) stuff_cnt <= stuff_cnt + 8'd1;
              run_cnt  <= RUN_ONE;
              last_bit <= din_in;
            end else if (run_cnt == RUN_MAX) begin
              stuff_err <= 1'b1;
              state     <= ERR;
            end else if (din_in == last_bit) begin
              dvalid  <= 1'b1;
              dout    <= din_in;
              run_cnt <= run_cnt + RUN_ONE;
            end else begin
              dvalid   <= 1'b1;
              dout     <= din_in;
              run_cnt  <= RUN_ONE;
              last_bit <= din_in;
            end
          end
        end
        ERR: begin
          // Bits are discarded until the frame is closed by frame_length_calc.
          if (!sample_en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_bit_destuff.sv
// Directed vector bench for can_bit_destuff: one table row per clk, outputs checked 1 clk later.
module tb_can_bit_destuff;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_in;
  logic       dvalid_in;
  logic       sof;
  logic       stuff_region;
  logic       sample_en;
  logic       dout;
  logic       dvalid;
  logic       stuff_drop;
  logic       stuff_err;
  logic [7:0] stuff_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  can_bit_destuff #(.STUFF_LEN(5), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .din_in       (din_in),
    .dvalid_in    (dvalid_in),
    .sof          (sof),
    .stuff_region (stuff_region),
    .sample_en    (sample_en),
    .dout         (dout),
    .dvalid       (dvalid),
    .stuff_drop   (stuff_drop),
    .stuff_err    (stuff_err),
    .stuff_cnt    (stuff_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, din, dv, sof, sr, sen;
    logic       edv, edout, cd, edrop, eerr;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vq[$];

  // cd = 1 means dout is compared on this row.
  function automatic void v(input logic r, input logic d, input logic dv, input logic s,
                            input logic sr, input logic se, input logic edv, input logic edout,
                            input logic cd, input logic edrop, input logic eerr,
                            input logic [7:0] ecnt);
    vec_t x;
    x.rst = r;  x.din = d;  x.dv = dv;  x.sof = s;  x.sr = sr;  x.sen = se;
    x.edv = edv; x.edout = edout; x.cd = cd; x.edrop = edrop; x.eerr = eerr; x.ecnt = ecnt;
    vq.push_back(x);
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; din_in = 1'b1; dvalid_in = 1'b0; sof = 1'b0;
    stuff_region = 1'b0; sample_en = 1'b0;

    // Reset, then 20 idle clks at reset values; a bit without sof is ignored.
    v(1,1,0,0,0,0, 0,1,1,0,0,8'd0);
    for (int k = 0; k < 20; k++) v(0,1,0,0,0,0, 0,1,1,0,0,8'd0);
    v(0,0,1,0,1,1, 0,1,1,0,0,8'd0);

    // Frame A: SOF + 0000, stuff 1 dropped, then 1111 completes a run with the stuff bit.
    v(0,0,1,1,1,1, 1,0,1,0,0,8'd0);
    for (int k = 0; k < 4; k++) v(0,0,1,0,1,1, 1,0,1,0,0,8'd0);
    v(0,1,1,0,1,1, 0,0,0,1,0,8'd1);
    for (int k = 0; k < 4; k++) v(0,1,1,0,1,1, 1,1,1,0,0,8'd1);
    v(0,0,1,0,1,1, 0,0,0,1,0,8'd2);
    v(0,0,0,0,1,1, 0,0,0,0,0,8'd2);            // no bit: no pulses
    v(0,1,1,1,1,1, 1,1,1,0,0,8'd2);            // sof inside RUN is just data
    v(0,0,1,0,0,1, 1,0,1,0,0,8'd2);            // stuff_region low: passthrough
    v(0,0,1,0,1,1, 1,0,1,0,0,8'd2);            // region re-rises: new run of 1
    for (int k = 0; k < 4; k++) v(0,0,1,0,1,1, 1,0,1,0,0,8'd2);
    v(0,1,1,0,1,1, 0,0,0,1,0,8'd3);            // 6th bit after re-rise is a stuff bit
    for (int k = 0; k < 7; k++) v(0,1,1,0,0,1, 1,1,1,0,0,8'd3);  // EOF recessive
    v(0,1,0,0,0,0, 0,0,0,0,0,8'd3);            // sample_en low -> IDLE
    v(0,0,1,0,1,1, 0,0,0,0,0,8'd3);            // no sof in IDLE: ignored

    // Frame B: stuff drop, then six recessive in a row -> stuff_err, ERR holds count.
    v(0,0,1,1,1,1, 1,0,1,0,0,8'd0);
    for (int k = 0; k < 4; k++) v(0,0,1,0,1,1, 1,0,1,0,0,8'd0);
    v(0,1,1,0,1,1, 0,0,0,1,0,8'd1);
    for (int k = 0; k < 4; k++) v(0,1,1,0,1,1, 1,1,1,0,0,8'd1);
    v(0,1,1,0,1,1, 0,0,0,0,1,8'd1);
    v(0,0,1,0,1,1, 0,0,0,0,0,8'd1);            // ERR ignores bits
    v(0,0,1,1,1,1, 0,0,0,0,0,8'd1);            // ERR ignores sof
    v(0,1,0,0,0,0, 0,0,0,0,0,8'd1);            // sample_en low -> IDLE

    // Frame C: accepted after ERR; reset with run_cnt = 4 aborts it.
    v(0,0,1,1,1,1, 1,0,1,0,0,8'd0);
    for (int k = 0; k < 3; k++) v(0,0,1,0,1,1, 1,0,1,0,0,8'd0);
    v(1,0,1,0,1,1, 0,1,1,0,0,8'd0);
    v(0,0,1,0,1,1, 0,1,1,0,0,8'd0);            // needs a fresh sof

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; din_in = vq[i].din; dvalid_in = vq[i].dv;
      sof = vq[i].sof; stuff_region = vq[i].sr; sample_en = vq[i].sen;
      @(posedge clk);
      #1;
      chk("dvalid", i, {7'd0, dvalid}, {7'd0, vq[i].edv});
      chk("stuff_drop", i, {7'd0, stuff_drop}, {7'd0, vq[i].edrop});
      chk("stuff_err", i, {7'd0, stuff_err}, {7'd0, vq[i].eerr});
      chk("stuff_cnt", i, stuff_cnt, vq[i].ecnt);
      if (vq[i].cd) chk("dout", i, {7'd0, dout}, {7'd0, vq[i].edout});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/can_bit_destuff.md
Name: can_bit_destuff

Overview:
- Sits between the bit sampler and frame_length_calc in the CAN Rx path.
- Takes one sampled bus bit per dvalid_in pulse and removes stuff bits. The first STUFF_LEN consecutive equal bits in the stuffed region are followed by one complementary bit, which this block drops.
- Flags stuff-rule violations and forwards the de-stuffed stream (dout/dvalid) to the frame length and field decode stages.

Parameters:
- STUFF_LEN, 5: number of consecutive equal bits that forces a stuff bit. Legal range is 2..15.
- CNT_W, 4: width of the run-length counter. Must satisfy 2^CNT_W > STUFF_LEN.

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst, input, 1: synchronous, active-high reset.
- din_in, input, 1: sampled CAN bit. 1 = recessive.
- dvalid_in, input, 1: one-cycle pulse per sampled bit.
- sof, input, 1: SOF detected. Coincident with the dvalid_in of the SOF bit.
- stuff_region, input, 1: high while the current bit lies in SOF..CRC sequence. Sampled with dvalid_in.
- sample_en, input, 1: high while a frame is in progress. Driven by frame_length_calc.
- dout, output, 1: de-stuffed bit.
- dvalid, output, 1: one-cycle pulse qualifying dout.
- stuff_drop, output, 1: one-cycle pulse when a stuff bit is removed.
- stuff_err, output, 1: one-cycle pulse on a stuff-rule violation.
- stuff_cnt, output, 8: stuff bits removed in the current frame. Saturates at 255.

Behaviour:
- Reset values (rst synchronous, wins over all other inputs):
  - state = IDLE, dout = 1, dvalid = 0, stuff_drop = 0, stuff_err = 0, stuff_cnt = 0.
  - Internal run_cnt = 0, last_bit = 1.
- Timing:
  - All outputs are registered.
  - dout/dvalid/stuff_drop/stuff_err assert exactly 1 clk after the triggering dvalid_in.
  - Pulses last 1 clk. With no qualifying event, dvalid/stuff_drop/stuff_err are 0.
- State machine has three states: IDLE, RUN, ERR.
- IDLE:
  - On dvalid_in & sof & din_in == 0: forward the bit (dvalid = 1, dout = 0), set run_cnt = 1, last_bit = 0, stuff_cnt = 0, go to RUN.
  - dvalid_in without sof is ignored: no output, no state change.
- RUN, processing each dvalid_in in priority order:
  1. sample_en == 0: go to IDLE. The bit is not forwarded. This check also applies in cycles without dvalid_in.
  2. stuff_region == 0: forward the bit unchanged and set run_cnt = 0. No stuff check is made.
  3. run_cnt == STUFF_LEN and din_in != last_bit: drop the bit (no dvalid), pulse stuff_drop, increment stuff_cnt (saturating), set run_cnt = 1, last_bit = din_in. The stuff bit starts the next run.
  4. run_cnt == STUFF_LEN and din_in == last_bit: pulse stuff_err, no dvalid, go to ERR.
  5. din_in == last_bit: forward the bit, run_cnt + 1.
  6. Otherwise: forward the bit, run_cnt = 1, last_bit = din_in.
- When stuff_region re-rises after a low period with run_cnt = 0, the first bit starts a new run (run_cnt = 1).
- ERR:
  - No outputs. dvalid_in is ignored.
  - Leaves to IDLE when sample_en == 0.
  - stuff_cnt holds its value until the next SOF.
- sof arriving while in RUN or ERR is ignored. A new frame starts only from IDLE.
- run_cnt never exceeds STUFF_LEN.
- Reset asserted mid-frame aborts immediately. The next frame requires a fresh sof.

Test Plan:
- Reset, then no stimulus → dout = 1, dvalid = 0, stuff_err = 0, stuff_cnt = 0 for 20 clks.
- SOF, then ID bits 0,0,0,0 (5 dominant total), then stuff bit 1, then 1 → 5 dvalid pulses of 0, then stuff_drop pulse with no dvalid, then dvalid dout = 1. stuff_cnt = 1. Each output occurs 1 clk after its dvalid_in.
- SOF + 0000 + 0 (sixth dominant) with stuff_region = 1 → stuff_err pulse 1 clk after the 6th bit, no dvalid, state ERR. Deassert sample_en → IDLE. A following SOF is accepted.
- Stuff bit 1 followed by 1111 (5 recessive including the stuff bit), then 0 → the 0 is dropped as a stuff bit and stuff_drop pulses. This proves the stuff bit counts toward the next run.
- Drop stuff_region after the CRC, then send 7 recessive EOF bits → all 7 forwarded with dvalid, no stuff_err. Then sample_en = 0 → IDLE.
- Assert rst mid-RUN with run_cnt = 4 → next clk all outputs at reset values. The next 0 without sof produces no dvalid.
